hapara_axis_barrier_client: RTL and testbench
=============================================

// Module: hapara_axis_barrier_client
// PURPOSE
//  Per-core initiator side of the AXI-Stream hardware barrier; one instance per slave core.
//  A core requests barrier entry. The block raises m_axis_tvalid and waits for the barrier
//  to assert m_axis_tready, which happens once every participant has arrived.
//  It then signals the core to proceed, and does not re-arm until the barrier drops
//  tready, so the barrier can always return to its waiting state.
// PARAMETERS
//  DATA_WIDTH      32  tdata width; must be >= 16
//  CORE_ID         0   8-bit identifier driven on tdata[7:0]
//  CNT_WIDTH       16  width of completed-barrier counter bar_count
//  TIMEOUT_CYCLES  0   ARRIVE cycles before bar_timeout is set; 0 disables timeout
// PORTS
//  m_axis_aclk     in   1           sole clock
//  m_axis_areset   in   1           asynchronous, active-high reset
//  m_axis_tvalid   out  1           barrier arrival, held until tready seen
//  m_axis_tdata    out  DATA_WIDTH  {bar_count zero-extended/truncated, CORE_ID[7:0]}
//  m_axis_tready   in   1           barrier locked (all participants arrived)
//  bar_req         in   1           core requests barrier entry; sampled each cycle
//  bar_busy        out  1           state != IDLE or pending set
//  bar_done        out  1           one-cycle pulse: barrier passed, core may proceed
//  bar_timeout     out  1           sticky: ARRIVE exceeded TIMEOUT_CYCLES
//  bar_overrun     out  1           sticky: bar_req arrived while pending already set
//  bar_count       out  CNT_WIDTH   completed barriers; wraps to 0 after all-ones
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; tvalid=0; done=0; timeout=0; overrun=0;
//    count=0; pending=0; timeout counter=0. Every output is registered.
//  States: IDLE, ARRIVE, LEAVE.
//  IDLE:
//    - Launch condition: (bar_req | pending) & !tready. On it, go to ARRIVE; tvalid=1 from the next cycle.
//    - bar_req with tready=1: set pending and stay IDLE. This covers barrier still locked, e.g. after reset.
//  ARRIVE:
//    - tvalid=1 and tdata held stable; pending cleared on entry.
//    - tready=1 sampled at an edge: go to LEAVE, tvalid=0, bar_done=1 for exactly one cycle,
//      bar_count+1, bar_timeout cleared, all in the cycle after that edge.
//    - Latency: tready high to done/tvalid-low is 1 cycle.
//  LEAVE:
//    - tvalid=0; wait for tready=0.
//    - On tready=0: go to ARRIVE if pending, else IDLE. ARRIVE re-entry is one cycle after tready low.
//    - tready may stay high for many cycles while other cores withdraw.
//  Handshake rules:
//    - tvalid never rises while tready=1.
//    - tvalid never falls before tready has been sampled high, except on reset.
//  Request queueing:
//    - bar_req outside IDLE-launch sets pending (a one-deep queue).
//    - bar_req while pending=1 and not consumed that cycle sets bar_overrun; the request is dropped.
//    - bar_req held as a level counts as one request per launch. The core deasserts it after bar_done.
//  Timeout:
//    - Counter runs only in ARRIVE and saturates.
//    - When it reaches TIMEOUT_CYCLES, bar_timeout=1. tvalid stays asserted (no withdrawal).
//    - Timeout counter resets on ARRIVE entry.
//  Simultaneous events:
//    - tready and bar_req in the same ARRIVE cycle: done fires and pending is set.
//    - bar_count wrap (all-ones + 1 gives 0) is legal, with no flag.
//  tdata: upper bits are bar_count as it was at ARRIVE entry, so the arrival carries its epoch.
// TESTING
//  T1 reset: assert m_axis_areset mid-ARRIVE -> tvalid=0 in same cycle, count=0, all flags 0.
//  T2 basic (CORE_ID=3):
//     stimulus: bar_req pulse at cyc2; tready 0 until cyc8, 1 for cyc8-10, then 0.
//     response: tvalid=1 cyc3-8, tdata=0x00000003, done pulse cyc9 only, count=1, IDLE by cyc12.
//  T3 stale lock: tready=1 at IDLE, bar_req at cyc2, tready falls cyc6 -> tvalid first high cyc7.
//  T4 queueing:
//     stimulus: bar_req during LEAVE (tready still 1); tready falls cyc20.
//     response: tvalid high cyc21 with tdata upper bits=1.
//     stimulus: second bar_req while pending -> response: bar_overrun=1.
//  T5 timeout (TIMEOUT_CYCLES=4):
//     stimulus: tready held 0 -> response: bar_timeout=1 after 4th ARRIVE cycle, tvalid still 1.
//     stimulus: then tready=1 -> response: done pulse, timeout cleared.
//  T6 wrap (CNT_WIDTH=2): 5 barriers -> bar_count sequence 1,2,3,0,1; one done per barrier.

Source files
------------

// File: rtl/hapara_axis_barrier_client.sv
// hapara_axis_barrier_client
// Per-core initiator for the AXI-Stream hardware barrier. The core asks to enter
// the barrier, this block announces the arrival with tvalid and holds it until the
// barrier locks (tready). It then pulses bar_done and waits for the barrier to
// release tready before it can arrive again. One extra request can be queued.
module hapara_axis_barrier_client #(
  parameter int DATA_WIDTH     = 32,
  parameter int CORE_ID        = 0,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  m_axis_aclk,
  input  logic                  m_axis_areset,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  input  logic                  m_axis_tready,
  input  logic                  bar_req,
  output logic                  bar_busy,
  output logic                  bar_done,
  output logic                  bar_timeout,
  output logic                  bar_overrun,
  output logic [CNT_WIDTH-1:0]  bar_count
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    ARRIVE,
    LEAVE
  } state_t;

  state_t                  state;
  logic                    pending;
  logic                    req_q;
  logic                    req_edge;
  logic                    want;
  logic [TW-1:0]           tcnt;
  logic [DATA_WIDTH-9:0]   epoch;
  logic [DATA_WIDTH-1:0]   launch_data;

  // A held request level only counts once, so requests are taken on the rising edge.
  assign req_edge = bar_req & ~req_q;
  assign want     = req_edge | pending;

  // Epoch field of tdata: bar_count zero-extended or truncated to the upper tdata bits.
  always_comb begin
    epoch = '0;
    for (int i = 0; i < DATA_WIDTH - 8 && i < CNT_WIDTH; i++) begin
      epoch[i] = bar_count[i];
    end
  end

  assign launch_data = {epoch, 8'(CORE_ID)};

  // Barrier handshake FSM with request queue, timeout and completion counter.
  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      state         <= IDLE;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      bar_busy      <= 1'b0;
      bar_done      <= 1'b0;
      bar_timeout   <= 1'b0;
      bar_overrun   <= 1'b0;
      bar_count     <= '0;
      pending       <= 1'b0;
      req_q         <= 1'b0;
      tcnt          <= '0;
    end else begin
      req_q    <= bar_req;
      bar_done <= 1'b0;
      case (state)
        // IDLE and LEAVE behave alike: with the barrier released we may (re)launch,
        // while it is still locked any new request only goes into the queue.
        IDLE, LEAVE: begin
          if (!m_axis_tready) begin
            if (want) begin
              state         <= ARRIVE;
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= launch_data;
              tcnt          <= '0;
              pending       <= pending & req_edge;
              bar_busy      <= 1'b1;
            end else begin
              state    <= IDLE;
              bar_busy <= 1'b0;
            end
          end else begin
            if (req_edge) begin
              pending <= 1'b1;
              if (pending) begin
                bar_overrun <= 1'b1;
              end
            end
            bar_busy <= (state == LEAVE) | pending | req_edge;
          end
        end
        ARRIVE: begin
          bar_busy <= 1'b1;
          if (req_edge) begin
            pending <= 1'b1;
            if (pending) begin
              bar_overrun <= 1'b1;
            end
          end
          if (m_axis_tready) begin
            state         <= LEAVE;
            m_axis_tvalid <= 1'b0;
            bar_done      <= 1'b1;
            bar_count     <= bar_count + 1'b1;
            bar_timeout   <= 1'b0;
          end else if (TIMEOUT_CYCLES != 0) begin
            if (tcnt != T_MAX) begin
              tcnt <= tcnt + 1'b1;
            end
            if (tcnt == T_LAST) begin
              bar_timeout <= 1'b1;
            end
          end
        end
        default: begin
          state         <= IDLE;
          m_axis_tvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hapara_axis_barrier_client.sv
// Testbench for hapara_axis_barrier_client: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_hapara_axis_barrier_client;

  localparam int DW = 32;
  localparam int CW = 2;
  localparam int TO = 4;
  localparam int ID = 3;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          tready = 1'b0;
  logic          req    = 1'b0;
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic          busy;
  logic          done;
  logic          timeout;
  logic          overrun;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit            mValid   = 1'b0;
  bit            mDone    = 1'b0;
  bit            mTimeout = 1'b0;
  bit            mOverrun = 1'b0;
  bit            mRelease = 1'b0;
  bit            mQueued  = 1'b0;
  bit            mPrev    = 1'b0;
  int            mEpoch   = 0;
  int            mWaited  = 0;
  logic [DW-1:0] mTdata   = '0;

  // Free-running clock
  always #5 clk = ~clk;

  hapara_axis_barrier_client #(
    .DATA_WIDTH     (DW),
    .CORE_ID        (ID),
    .CNT_WIDTH      (CW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .m_axis_aclk   (clk),
    .m_axis_areset (rst),
    .m_axis_tvalid (tvalid),
    .m_axis_tdata  (tdata),
    .m_axis_tready (tready),
    .bar_req       (req),
    .bar_busy      (busy),
    .bar_done      (done),
    .bar_timeout   (timeout),
    .bar_overrun   (overrun),
    .bar_count     (count)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic t);
    req    = r;
    tready = t;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #2;
  endtask

  task automatic resetDut(input string tag);
    nextCycle();
    rst = 1'b1;
    #1;
    checkOutput({tag, ".tvalid"}, 32'(tvalid), 0);
    checkOutput({tag, ".count"}, 32'(count), 0);
    checkOutput({tag, ".done"}, 32'(done), 0);
    checkOutput({tag, ".timeout"}, 32'(timeout), 0);
    checkOutput({tag, ".overrun"}, 32'(overrun), 0);
    checkOutput({tag, ".busy"}, 32'(busy), 0);
    applyStimulus(1'b0, 1'b0);
    repeat (2) nextCycle();
    rst = 1'b0;
  endtask

  // Model: the core is either at the barrier (valid), waiting for the lock to
  // release, or free. Requests are rising edges; one may wait in the queue.
  always @(posedge clk or posedge rst) begin : model
    bit newReq;
    int want;
    if (rst) begin
      mValid = 0; mDone = 0; mTimeout = 0; mOverrun = 0;
      mRelease = 0; mQueued = 0; mPrev = 0; mEpoch = 0; mWaited = 0;
    end else begin
      newReq = req && !mPrev;
      mPrev  = req;
      mDone  = 0;
      if (mValid) begin
        if (newReq) begin
          if (mQueued) mOverrun = 1; else mQueued = 1;
        end
        if (tready) begin
          mValid   = 0;
          mDone    = 1;
          mEpoch   = (mEpoch + 1) % (1 << CW);
          mTimeout = 0;
          mRelease = 1;
        end else begin
          mWaited++;
          if (TO > 0 && mWaited >= TO) mTimeout = 1;
        end
      end else if (tready) begin
        if (newReq) begin
          if (mQueued) mOverrun = 1; else mQueued = 1;
        end
      end else begin
        mRelease = 0;
        want = int'(mQueued) + int'(newReq);
        if (want > 0) begin
          mValid  = 1;
          mTdata  = DW'((mEpoch << 8) | ID);
          mWaited = 0;
          mQueued = (want == 2);
        end
      end
    end
  end

  // Compare DUT against the model mid-cycle whenever reset is released.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("cmp.tvalid", 32'(tvalid), 32'(mValid));
      checkOutput("cmp.done", 32'(done), 32'(mDone));
      checkOutput("cmp.timeout", 32'(timeout), 32'(mTimeout));
      checkOutput("cmp.overrun", 32'(overrun), 32'(mOverrun));
      checkOutput("cmp.count", 32'(count), 32'(mEpoch));
      checkOutput("cmp.busy", 32'(busy), 32'(mValid || mRelease || mQueued));
      if (mValid) checkOutput("cmp.tdata", tdata, mTdata);
    end
  end

  // Directed scenarios
  initial begin : stimulus
    int expSeq[5];
    int dones;
    expSeq = '{1, 2, 3, 0, 1};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.tvalid", 32'(tvalid), 0);
    checkOutput("rst.count", 32'(count), 0);
    checkOutput("rst.busy", 32'(busy), 0);
    checkOutput("rst.flags", {29'd0, done, timeout, overrun}, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // T2 basic barrier
    for (int c = 0; c <= 13; c++) begin
      nextCycle();
      checkOutput($sformatf("T2.tvalid@%0d", c), 32'(tvalid), 32'(c >= 3 && c <= 8));
      checkOutput($sformatf("T2.done@%0d", c), 32'(done), 32'(c == 9));
      if (c == 3) checkOutput("T2.tdata", tdata, 32'h0000_0003);
      if (c == 12) begin
        checkOutput("T2.count", 32'(count), 1);
        checkOutput("T2.busy", 32'(busy), 0);
      end
      applyStimulus(c == 2, c >= 8 && c <= 10);
    end

    // T3 stale lock at IDLE
    for (int c = 0; c <= 12; c++) begin
      nextCycle();
      if (c <= 6) checkOutput($sformatf("T3.tvalid@%0d", c), 32'(tvalid), 0);
      if (c == 3) checkOutput("T3.busy", 32'(busy), 1);
      if (c == 7) begin
        checkOutput("T3.tvalid@7", 32'(tvalid), 1);
        checkOutput("T3.tdata", tdata, 32'h0000_0103);
      end
      if (c == 10) checkOutput("T3.done", 32'(done), 1);
      if (c == 12) checkOutput("T3.count", 32'(count), 2);
      applyStimulus(c == 2, c <= 5 || c == 9 || c == 10);
    end

    // T5 timeout
    for (int c = 0; c <= 12; c++) begin
      nextCycle();
      if (c == 6) checkOutput("T5.timeout@6", 32'(timeout), 0);
      if (c == 7) begin
        checkOutput("T5.timeout@7", 32'(timeout), 1);
        checkOutput("T5.tdata", tdata, 32'h0000_0203);
      end
      if (c == 8) checkOutput("T5.tvalid@8", 32'(tvalid), 1);
      if (c == 10) begin
        checkOutput("T5.done", 32'(done), 1);
        checkOutput("T5.timeout@10", 32'(timeout), 0);
      end
      if (c == 12) checkOutput("T5.count", 32'(count), 3);
      applyStimulus(c == 2, c == 9 || c == 10);
    end

    // T1 reset in the middle of ARRIVE
    for (int c = 0; c <= 4; c++) begin
      nextCycle();
      applyStimulus(c == 2, 1'b0);
    end
    nextCycle();
    checkOutput("T1.armed", 32'(tvalid), 1);
    rst = 1'b1;
    #1;
    checkOutput("T1.tvalid", 32'(tvalid), 0);
    checkOutput("T1.count", 32'(count), 0);
    checkOutput("T1.flags", {29'd0, done, timeout, overrun}, 0);
    checkOutput("T1.busy", 32'(busy), 0);
    repeat (2) nextCycle();
    rst = 1'b0;

    // T4 queueing during LEAVE and overrun
    for (int c = 0; c <= 28; c++) begin
      nextCycle();
      if (c == 9) begin
        checkOutput("T4.done@9", 32'(done), 1);
        checkOutput("T4.count@9", 32'(count), 1);
      end
      if (c == 15) checkOutput("T4.overrun@15", 32'(overrun), 0);
      if (c == 16) checkOutput("T4.overrun@16", 32'(overrun), 1);
      if (c == 20) checkOutput("T4.tvalid@20", 32'(tvalid), 0);
      if (c == 21) begin
        checkOutput("T4.tvalid@21", 32'(tvalid), 1);
        checkOutput("T4.tdata", tdata, 32'h0000_0103);
      end
      if (c == 25) checkOutput("T4.done@25", 32'(done), 1);
      if (c == 28) begin
        checkOutput("T4.busy", 32'(busy), 0);
        checkOutput("T4.tvalid@28", 32'(tvalid), 0);
        checkOutput("T4.count@28", 32'(count), 2);
      end
      applyStimulus(c == 2 || c == 12 || c == 15, (c >= 8 && c <= 19) || (c >= 24 && c <= 26));
    end

    // T6 counter wrap
    resetDut("T6rst");
    for (int b = 0; b < 5; b++) begin
      dones = 0;
      for (int c = 0; c <= 7; c++) begin
        nextCycle();
        if (done) dones++;
        applyStimulus(c == 0, c == 3 || c == 4);
      end
      checkOutput($sformatf("T6.count%0d", b), 32'(count), 32'(expSeq[b]));
      checkOutput($sformatf("T6.dones%0d", b), 32'(dones), 1);
    end

    repeat (2) nextCycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
